// File: rtl/srng_poller_pkg.sv
// srng_poller_pkg: shared definitions for the srng poller.
//   ADDR_STATUS / ADDR_DATA     register map of the srng core
//   STATUS_READY_BIT / _ERROR_  bit positions inside the status word
//   state_t                     poller FSM state encoding
//   data_addr()                 address of the idx-th entropy data register
package srng_poller_pkg;

    localparam logic [7:0] ADDR_STATUS      = 8'h09;
    localparam logic [7:0] ADDR_DATA        = 8'h10;
    localparam int         STATUS_READY_BIT = 0;
    localparam int         STATUS_ERROR_BIT = 1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT,
        ST_POLL,
        ST_READ,
        ST_OUT,
        ST_ERROR
    } state_t;

    function automatic logic [7:0] data_addr(input logic [7:0] idx);
        return ADDR_DATA + idx;
    endfunction

endpackage

// File: rtl/srng_poller.sv
// srng_poller: periodically polls an srng core for ready status, then reads a
// batch of NUM_WORDS entropy words and streams them out over valid/ready.
//   clk, reset_n            clock, asynchronous active-low reset
//   enable                  level-sensitive run request
//   core_cs/we/address/...  register bus to the srng core (read-only use)
//   core_read_data          combinational read data, valid while core_cs=1
//   out_data/valid/ready    entropy word stream
//   display                 low DISP_WIDTH bits of the last accepted word
//   error                   sticky core error, cleared by dropping enable
//   timeout                 one-cycle pulse when polling gives up
//   word_count              total accepted words (wraps)
module srng_poller
    import srng_poller_pkg::*;
#(
    parameter int unsigned WAIT_CYCLES  = 32'h0040_0000,
    parameter int unsigned POLL_TIMEOUT = 1024,
    parameter int unsigned NUM_WORDS    = 4,
    parameter int unsigned DISP_WIDTH   = 8
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  enable,
    output logic                  core_cs,
    output logic                  core_we,
    output logic [7:0]            core_address,
    output logic [31:0]           core_write_data,
    input  logic [31:0]           core_read_data,
    output logic [31:0]           out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DISP_WIDTH-1:0] display,
    output logic                  error,
    output logic                  timeout,
    output logic [31:0]           word_count
);

    // +1 keeps the widths non-zero when a parameter is 1
    localparam int WCW = $clog2(WAIT_CYCLES + 1);
    localparam int PCW = $clog2(POLL_TIMEOUT + 1);
    localparam int NCW = $clog2(NUM_WORDS + 1);

    localparam logic [WCW-1:0] WAIT_LAST = WCW'(WAIT_CYCLES - 1);
    localparam logic [PCW-1:0] POLL_LAST = PCW'(POLL_TIMEOUT - 1);
    localparam logic [NCW-1:0] WORD_LAST = NCW'(NUM_WORDS - 1);

    state_t         state;
    logic [WCW-1:0] wait_ctr;
    logic [PCW-1:0] poll_ctr;
    logic [NCW-1:0] word_ctr;

    // The poller never writes the core
    assign core_we         = 1'b0;
    assign core_write_data = 32'h0;

    // core_cs/core_address are registered alongside the state, so they are
    // set on the transition into POLL/READ and are valid throughout that
    // state, which is when core_read_data is sampled.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= ST_IDLE;
            wait_ctr     <= '0;
            poll_ctr     <= '0;
            word_ctr     <= '0;
            core_cs      <= 1'b0;
            core_address <= 8'h00;
            out_data     <= 32'h0;
            out_valid    <= 1'b0;
            display      <= '0;
            error        <= 1'b0;
            timeout      <= 1'b0;
            word_count   <= 32'h0;
        end else begin
            timeout <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (enable) begin
                        state    <= ST_WAIT;
                        wait_ctr <= '0;
                    end
                end

                ST_WAIT: begin
                    if (!enable) begin
                        state <= ST_IDLE;
                    end else if (wait_ctr == WAIT_LAST) begin
                        state        <= ST_POLL;
                        poll_ctr     <= '0;
                        core_cs      <= 1'b1;
                        core_address <= ADDR_STATUS;
                    end else begin
                        wait_ctr <= wait_ctr + 1'b1;
                    end
                end

                ST_POLL: begin
                    if (!enable) begin
                        state        <= ST_IDLE;
                        core_cs      <= 1'b0;
                        core_address <= 8'h00;
                    end else if (core_read_data[STATUS_ERROR_BIT]) begin
                        state        <= ST_ERROR;
                        error        <= 1'b1;
                        core_cs      <= 1'b0;
                        core_address <= 8'h00;
                    end else if (core_read_data[STATUS_READY_BIT]) begin
                        // cs stays high; just retarget to the data register
                        state        <= ST_READ;
                        core_address <= data_addr(8'(word_ctr));
                    end else if (poll_ctr == POLL_LAST) begin
                        timeout      <= 1'b1;
                        state        <= ST_WAIT;
                        wait_ctr     <= '0;
                        core_cs      <= 1'b0;
                        core_address <= 8'h00;
                    end else begin
                        poll_ctr <= poll_ctr + 1'b1;
                    end
                end

                ST_READ: begin
                    out_data     <= core_read_data;
                    out_valid    <= 1'b1;
                    core_cs      <= 1'b0;
                    core_address <= 8'h00;
                    state        <= ST_OUT;
                end

                // enable is deliberately not looked at here: a started batch
                // always runs to completion and WAIT then drops to IDLE.
                ST_OUT: begin
                    if (out_ready) begin
                        out_valid  <= 1'b0;
                        display    <= out_data[DISP_WIDTH-1:0];
                        word_count <= word_count + 32'd1;
                        if (word_ctr == WORD_LAST) begin
                            word_ctr <= '0;
                            wait_ctr <= '0;
                            state    <= ST_WAIT;
                        end else begin
                            word_ctr     <= word_ctr + 1'b1;
                            state        <= ST_READ;
                            core_cs      <= 1'b1;
                            core_address <= data_addr(8'(word_ctr + 1'b1));
                        end
                    end
                end

                ST_ERROR: begin
                    if (!enable) begin
                        state <= ST_IDLE;
                        error <= 1'b0;
                    end
                end

                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
